counter_threshold_monitor16: RTL and testbench
==============================================

COUNTER_THRESHOLD_MONITOR16 -- requirements
Module: counter_threshold_monitor16

Interface
REQ-001 SHALL have parameter HOLD, default 4: irq assertion length in cycles, legal range 1..255.
REQ-002 SHALL have port clock0, input, 1 bit: the single clock; all state updates on its falling edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset sampled on the falling edge of clock0.
REQ-004 SHALL have port count, input, 16 bits: the free-running value from the upstream 16-bit up counter.
REQ-005 SHALL have port threshold, input, 16 bits: the compare value, sampled every edge.
REQ-006 SHALL have port arm, input, 1 bit: request IDLE->ARMED.
REQ-007 SHALL have port clear, input, 1 bit: return to IDLE and zero wrap_count.
REQ-008 SHALL have port match_pulse, output, 1 bit, registered: one-cycle pulse per new threshold match.
REQ-009 SHALL have port wrap_pulse, output, 1 bit, registered: one-cycle pulse per detected 0xFFFF->0x0000 wrap.
REQ-010 SHALL have port wrap_count, output, 8 bits, registered: saturating count of wraps.
REQ-011 SHALL have port state, output, 2 bits: FSM encoding, IDLE=00, ARMED=01, TRIGGERED=10, DONE=11.
REQ-012 SHALL have port irq, output, 1 bit, registered: high only in TRIGGERED.

Function
REQ-013 SHALL register count into count_d each edge and set prev_valid to 1 on the first non-reset edge.
REQ-014 SHALL set wrap_pulse <= prev_valid && count_d==16'hFFFF && count==16'h0000; otherwise 0.
REQ-015 SHALL set match_pulse <= (count==threshold) && (!prev_valid || count_d!=threshold), so a count held at threshold pulses once only.
REQ-016 SHALL use the unregistered match condition (the same expression as REQ-015) as the FSM's "match" event in the same edge in which match_pulse is loaded.
REQ-017 SHALL increment wrap_count on every wrap condition, saturating at 8'hFF with no roll-over.
REQ-018 SHALL give clear priority over a wrap increment in the same edge; wrap_count becomes 0, while wrap_pulse still asserts.
REQ-019 SHALL make the FSM in IDLE go to ARMED on arm=1; a simultaneous match is ignored.
REQ-020 SHALL make the FSM in ARMED go to TRIGGERED on match; arm is ignored.
REQ-021 SHALL, on entering TRIGGERED, load a hold counter with HOLD-1 and drive irq=1; the FSM goes to DONE when the hold counter reaches 0, so irq is high exactly HOLD cycles.
REQ-022 SHALL hold the FSM in DONE with irq=0 until clear; arm and match are ignored.
REQ-023 SHALL send the FSM to IDLE on clear=1 from any state, taking priority over arm, match and hold expiry, with irq=0 on the next cycle.
REQ-024 SHALL generate match_pulse and wrap_pulse in every FSM state, unaffected by arm or clear.
REQ-025 SHALL treat threshold changes as taking effect at the next edge; there is no shadowing.

Reset
REQ-026 SHALL, on reset=1 at a falling edge, clear match_pulse, wrap_pulse and irq to 0, wrap_count to 8'h00, state to IDLE, count_d to 0, prev_valid to 0, and the hold counter to 0.
REQ-027 SHALL give reset priority over clear, arm and every detection, including mid-TRIGGERED, where irq drops on the next cycle.
REQ-028 SHALL make the first edge after reset able to produce match_pulse but never wrap_pulse.

Verification
REQ-029 SHALL cover this scenario: reset, threshold=16'h0005, arm pulsed, count 0..8 -> state 01 after arm; match_pulse one cycle after count==5 is sampled; state 10 with irq high 4 cycles, then state 11 with irq 0.
REQ-030 SHALL cover this scenario: count 16'hFFFE, FFFF, 0000, 0001 -> wrap_pulse high exactly one cycle after sampling 0000; wrap_count 0->1.
REQ-031 SHALL cover this scenario: 300 forced wrap sequences -> wrap_count saturates at 8'hFF, and wrap_pulse still pulses 300 times.
REQ-032 SHALL cover this scenario: count held at threshold=16'h0010 for 10 cycles while ARMED -> exactly one match_pulse and one trigger.
REQ-033 SHALL cover this scenario: clear asserted in the same edge as a wrap and as hold expiry -> wrap_count=0, wrap_pulse=1, state 00, irq 0.
REQ-034 SHALL cover this scenario: reset asserted during TRIGGERED (2nd irq cycle) with count=16'h0000 and threshold=16'h0000, then released -> all outputs 0, state 00; first post-reset edge gives match_pulse=1 and wrap_pulse=0.

Source files
------------

// File: rtl/counter_threshold_monitor16.sv
// Threshold/wrap monitor for a free-running 16-bit counter: pulses on new threshold
// matches and 0xFFFF->0x0000 wraps, and raises irq for HOLD cycles after an armed match.
module counter_threshold_monitor16 #(
  parameter int HOLD = 4
) (
  input  logic        clock0,
  input  logic        reset,
  input  logic [15:0] count,
  input  logic [15:0] threshold,
  input  logic        arm,
  input  logic        clear,
  output logic        match_pulse,
  output logic        wrap_pulse,
  output logic [7:0]  wrap_count,
  output logic [1:0]  state,
  output logic        irq
);

  localparam logic [1:0] IDLE      = 2'b00;
  localparam logic [1:0] ARMED     = 2'b01;
  localparam logic [1:0] TRIGGERED = 2'b10;
  localparam logic [1:0] DONE      = 2'b11;

  localparam logic [7:0] HOLD_INIT = 8'(HOLD - 1);

  logic [15:0] count_d_reg;
  logic        prev_valid_reg;
  logic [7:0]  hold_reg, hold_next;
  logic [1:0]  state_reg, state_next;
  logic        irq_reg, irq_next;
  logic [7:0]  wrap_count_reg, wrap_count_next;
  logic        match_pulse_reg, wrap_pulse_reg;
  logic        match_now, wrap_now;

  // A count parked on the threshold only matches on the edge it arrives.
  assign match_now = (count == threshold) && (!prev_valid_reg || (count_d_reg != threshold));
  assign wrap_now  = prev_valid_reg && (count_d_reg == 16'hFFFF) && (count == 16'h0000);

  always_comb begin
    wrap_count_next = wrap_count_reg;
    if (clear) begin
      wrap_count_next = 8'h00;
    end else if (wrap_now && (wrap_count_reg != 8'hFF)) begin
      wrap_count_next = wrap_count_reg + 8'h01;
    end
  end

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    irq_next   = irq_reg;
    if (clear) begin
      state_next = IDLE;
      hold_next  = 8'h00;
      irq_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arm) state_next = ARMED;
        end
        ARMED: begin
          if (match_now) begin
            state_next = TRIGGERED;
            hold_next  = HOLD_INIT;
            irq_next   = 1'b1;
          end
        end
        TRIGGERED: begin
          // hold_reg counts the irq cycles still owed after the current one.
          if (hold_reg == 8'h00) begin
            state_next = DONE;
            irq_next   = 1'b0;
          end else begin
            hold_next = hold_reg - 8'h01;
          end
        end
        DONE: begin
          irq_next = 1'b0;
        end
        default: begin
          state_next = IDLE;
          irq_next   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(negedge clock0) begin
    if (reset) begin
      count_d_reg     <= 16'h0000;
      prev_valid_reg  <= 1'b0;
      match_pulse_reg <= 1'b0;
      wrap_pulse_reg  <= 1'b0;
      wrap_count_reg  <= 8'h00;
      state_reg       <= IDLE;
      hold_reg        <= 8'h00;
      irq_reg         <= 1'b0;
    end else begin
      count_d_reg     <= count;
      prev_valid_reg  <= 1'b1;
      match_pulse_reg <= match_now;
      wrap_pulse_reg  <= wrap_now;
      wrap_count_reg  <= wrap_count_next;
      state_reg       <= state_next;
      hold_reg        <= hold_next;
      irq_reg         <= irq_next;
    end
  end

  assign match_pulse = match_pulse_reg;
  assign wrap_pulse  = wrap_pulse_reg;
  assign wrap_count  = wrap_count_reg;
  assign state       = state_reg;
  assign irq         = irq_reg;

endmodule

// File: tb/tb_counter_threshold_monitor16.sv
// Scoreboard bench for counter_threshold_monitor16: directed scenarios plus random traffic,
// each edge predicted by a behavioural model and compared by an independent monitor.
module tb_counter_threshold_monitor16;

  localparam int HOLD = 4;
  localparam int NPH  = 8;

  logic        clock0 = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] count = 16'h0000;
  logic [15:0] threshold = 16'h0000;
  logic        arm = 1'b0;
  logic        clear = 1'b0;
  logic        match_pulse, wrap_pulse, irq;
  logic [7:0]  wrap_count;
  logic [1:0]  state;

  counter_threshold_monitor16 #(.HOLD(HOLD)) dut (
    .clock0      (clock0),
    .reset       (reset),
    .count       (count),
    .threshold   (threshold),
    .arm         (arm),
    .clear       (clear),
    .match_pulse (match_pulse),
    .wrap_pulse  (wrap_pulse),
    .wrap_count  (wrap_count),
    .state       (state),
    .irq         (irq)
  );

  always #5 clock0 = ~clock0;

  typedef struct {
    logic [12:0] v;   // {match, wrap, wrap_count, state, irq}
    int          ph;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cur_ph = 0;
  int n_match[NPH];
  int n_wrap[NPH];
  int n_irq[NPH];
  int n_trig[NPH];

  // Reference model: behaviour expressed as "previous sample", "irq cycles served", "wraps seen".
  int md_cnt = 0;
  bit md_pv = 0;
  int md_state = 0;   // 0 idle, 1 armed, 2 triggered, 3 done
  int md_served = 0;
  int md_wraps = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic step(input bit r, input int c, input int t, input bit a, input bit cl);
    exp_t e;
    bit hit, wr;
    @(posedge clock0);
    #1;
    reset = r; count = c[15:0]; threshold = t[15:0]; arm = a; clear = cl;
    hit = 0; wr = 0;
    if (r) begin
      md_cnt = 0; md_pv = 0; md_state = 0; md_served = 0; md_wraps = 0;
    end else begin
      hit = (c == t) && (!md_pv || md_cnt != t);
      wr  = md_pv && md_cnt == 65535 && c == 0;
      if (cl) md_wraps = 0;
      else if (wr && md_wraps < 255) md_wraps++;
      if (cl) begin
        md_state = 0; md_served = 0;
      end else begin
        case (md_state)
          0: if (a) md_state = 1;
          1: if (hit) begin md_state = 2; md_served = 1; end
          2: if (md_served == HOLD) md_state = 3; else md_served++;
          default: ;
        endcase
      end
      md_cnt = c; md_pv = 1;
    end
    e.v  = {hit, wr, 8'(md_wraps), 2'(md_state), (md_state == 2)};
    e.ph = cur_ph;
    q.push_back(e);
  endtask

  // Monitor: DUT updates on the falling edge; sample shortly after it.
  initial begin
    exp_t e;
    logic [12:0] act;
    logic [1:0] prev_st;
    prev_st = 2'b00;
    for (int i = 0; i < NPH; i++) begin
      n_match[i] = 0; n_wrap[i] = 0; n_irq[i] = 0; n_trig[i] = 0;
    end
    forever begin
      @(negedge clock0);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {match_pulse, wrap_pulse, wrap_count, state, irq};
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL cycle_ph%0d: got m=%b w=%b wc=%h st=%b irq=%b expected m=%b w=%b wc=%h st=%b irq=%b",
                   e.ph, act[12], act[11], act[10:3], act[2:1], act[0],
                   e.v[12], e.v[11], e.v[10:3], e.v[2:1], e.v[0]);
        end
        if (match_pulse === 1'b1) n_match[e.ph]++;
        if (wrap_pulse === 1'b1) n_wrap[e.ph]++;
        if (irq === 1'b1) n_irq[e.ph]++;
        if (state === 2'b10 && prev_st !== 2'b10) n_trig[e.ph]++;
        prev_st = state;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int t;
    int rnd;
    // Reset
    cur_ph = 0;
    step(1, 0, 5, 0, 0);
    step(1, 0, 5, 0, 0);
    // Arm, then count through threshold 5
    cur_ph = 1;
    step(0, 0, 5, 1, 0);
    for (int i = 1; i <= 12; i++) step(0, i, 5, 0, 0);
    // Single wrap
    cur_ph = 2;
    step(0, 100, 5, 0, 1);
    step(0, 16'hFFFE, 5, 0, 0);
    step(0, 16'hFFFF, 5, 0, 0);
    step(0, 16'h0000, 5, 0, 0);
    step(0, 16'h0001, 5, 0, 0);
    // 300 wraps, counter saturates
    cur_ph = 3;
    for (int i = 0; i < 300; i++) begin
      step(0, 16'hFFFF, 5, 0, 0);
      step(0, 16'h0000, 5, 0, 0);
    end
    // Count parked on threshold while armed
    cur_ph = 4;
    step(0, 0, 16'h10, 0, 1);
    step(0, 1, 16'h10, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 16'h10, 16'h10, 0, 0);
    // Clear coinciding with wrap and hold expiry
    cur_ph = 5;
    step(0, 0, 16'h20, 0, 1);
    step(0, 1, 16'h20, 1, 0);
    step(0, 16'h20, 16'h20, 0, 0);
    step(0, 16'h21, 16'h20, 0, 0);
    step(0, 16'h22, 16'h20, 0, 0);
    step(0, 16'hFFFF, 16'h20, 0, 0);
    step(0, 16'h0000, 16'h20, 0, 1);
    // Reset during triggered with count = threshold = 0
    cur_ph = 6;
    step(0, 5, 0, 0, 1);
    step(0, 5, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // Random traffic
    cur_ph = 7;
    c = 16'hFFF0;
    t = 16'hFFF8;
    for (int i = 0; i < 800; i++) begin
      rnd = $urandom_range(0, 99);
      if (rnd < 70) c = (c + 1) & 16'hFFFF;
      else if (rnd < 80) c = 16'hFFFF;
      else if (rnd < 90) c = 0;
      else c = $urandom_range(0, 65535);
      if ($urandom_range(0, 9) == 0) begin
        rnd = $urandom_range(0, 3);
        t = (rnd == 0) ? 0 : (rnd == 1) ? 16'hFFFF : (rnd == 2) ? ((c + $urandom_range(0, 6)) & 16'hFFFF)
                                                                 : $urandom_range(0, 65535);
      end
      step($urandom_range(0, 99) < 2, c, t, $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0);
    end
    // Let the monitor consume the final expectation
    @(posedge clock0);
    #1;
    step(0, c, t, 0, 0);
    @(negedge clock0);
    #4;
    chk("queue_drained", q.size(), 0);
    chk("ph1_match_pulses", n_match[1], 1);
    chk("ph1_irq_cycles", n_irq[1], HOLD);
    chk("ph1_triggers", n_trig[1], 1);
    chk("ph2_wrap_pulses", n_wrap[2], 1);
    chk("ph3_wrap_pulses", n_wrap[3], 300);
    chk("ph4_match_pulses", n_match[4], 1);
    chk("ph4_triggers", n_trig[4], 1);
    chk("ph5_wrap_pulses", n_wrap[5], 1);
    chk("ph6_match_pulses", n_match[6], 2);
    chk("ph6_wrap_pulses", n_wrap[6], 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
